// File: rtl/gen_scheduler.sv
// rtl/gen_scheduler.sv - board sequencer: paces life-engine generations and serialises cursor edits
// Edits and generations share the board, so one FSM grants it to one of them at a time.
module gen_scheduler #(
  parameter int POS_W           = 10,
  parameter int LOG_BASE_PERIOD = 20,
  parameter int GEN_CNT_W       = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [2:0]           speed_in,
  input  logic                 step_in,
  input  logic                 click_in,
  input  logic [POS_W-1:0]     cursor_x_in,
  input  logic [POS_W-1:0]     cursor_y_in,
  output logic                 gen_start_out,
  input  logic                 gen_done_in,
  output logic                 gen_busy_out,
  output logic [POS_W-1:0]     edit_x_out,
  output logic [POS_W-1:0]     edit_y_out,
  output logic                 edit_re_out,
  input  logic                 edit_rdata_in,
  output logic                 edit_we_out,
  output logic                 edit_wdata_out,
  output logic [GEN_CNT_W-1:0] gen_count_out,
  output logic                 overrun_out
);

  localparam int CNT_W = LOG_BASE_PERIOD + 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_RD,
    S_EDIT_WR,
    S_GEN_START,
    S_GEN_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]     period_m1;
  logic [2:0]           speed_q;
  logic                 speed_chg;
  logic                 tick;
  logic                 step_pend_q, step_pend_d;
  logic                 step_live;
  logic                 edit_pend_q, edit_pend_d;
  logic                 overrun_q, overrun_d;
  logic [POS_W-1:0]     edit_x_q, edit_x_d;
  logic [POS_W-1:0]     edit_y_q, edit_y_d;
  logic [GEN_CNT_W-1:0] gen_count_q, gen_count_d;

  // Period is 2^(CNT_W-speed), so the terminal count is the all-ones mask shifted by speed.
  assign period_m1 = {CNT_W{1'b1}} >> speed_in;
  assign speed_chg = (speed_in != speed_q);

  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q + CNT_W'(1);
    if (speed_in == 3'd0 || speed_chg) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == period_m1) begin
      tick_cnt_d = '0;
      tick       = 1'b1;
    end
  end

  // A step being launched this cycle is already consumed, so a coincident tick re-arms it.
  assign step_live = step_pend_q && (state_q != S_GEN_START);

  always_comb begin
    step_pend_d = step_live;
    overrun_d   = overrun_q;
    if (speed_in == 3'd0 && speed_q != 3'd0) begin
      step_pend_d = 1'b0;
    end
    if (tick) begin
      if (step_live) begin
        overrun_d = 1'b1;
      end else begin
        step_pend_d = 1'b1;
      end
    end
    if (speed_in == 3'd0 && step_in) begin
      step_pend_d = 1'b1;
    end
  end

  always_comb begin
    edit_pend_d = edit_pend_q && (state_q != S_EDIT_WR);
    edit_x_d    = edit_x_q;
    edit_y_d    = edit_y_q;
    if (click_in && !edit_pend_q) begin
      edit_pend_d = 1'b1;
      edit_x_d    = cursor_x_in;
      edit_y_d    = cursor_y_in;
    end
  end

  always_comb begin
    state_d        = state_q;
    gen_count_d    = gen_count_q;
    gen_start_out  = 1'b0;
    gen_busy_out   = 1'b0;
    edit_re_out    = 1'b0;
    edit_we_out    = 1'b0;
    edit_wdata_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (edit_pend_q) begin
          state_d = S_EDIT_RD;
        end else if (step_pend_q) begin
          state_d = S_GEN_START;
        end
      end
      S_EDIT_RD: begin
        edit_re_out = 1'b1;
        state_d     = S_EDIT_WR;
      end
      S_EDIT_WR: begin
        edit_we_out    = 1'b1;
        edit_wdata_out = ~edit_rdata_in;
        state_d        = S_IDLE;
      end
      S_GEN_START: begin
        gen_start_out = 1'b1;
        gen_busy_out  = 1'b1;
        state_d       = S_GEN_WAIT;
      end
      S_GEN_WAIT: begin
        gen_busy_out = 1'b1;
        if (gen_done_in) begin
          gen_count_d = gen_count_q + GEN_CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      speed_q     <= '0;
      step_pend_q <= 1'b0;
      edit_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      edit_x_q    <= '0;
      edit_y_q    <= '0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      speed_q     <= speed_in;
      step_pend_q <= step_pend_d;
      edit_pend_q <= edit_pend_d;
      overrun_q   <= overrun_d;
      edit_x_q    <= edit_x_d;
      edit_y_q    <= edit_y_d;
      gen_count_q <= gen_count_d;
    end
  end

  assign edit_x_out    = edit_x_q;
  assign edit_y_out    = edit_y_q;
  assign gen_count_out = gen_count_q;
  assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// tb/tb_gen_scheduler.sv - scoreboard bench for gen_scheduler
module tb_gen_scheduler;

  localparam int POS_W = 10;
  localparam int CW    = 8;
  localparam int NWRAP = 1 << CW;

  localparam int K_START = 1;
  localparam int K_RE    = 2;
  localparam int K_WE    = 3;

  typedef struct {
    int kind;
    int cyc;
    int x;
    int y;
    int d;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       speed = 3'd0;
  logic             step = 1'b0;
  logic             click = 1'b0;
  logic [POS_W-1:0] cx = '0;
  logic [POS_W-1:0] cy = '0;
  logic             gen_start;
  logic             gen_done;
  logic             gen_busy;
  logic [POS_W-1:0] ex;
  logic [POS_W-1:0] ey;
  logic             edit_re;
  logic             rdata = 1'b0;
  logic             edit_we;
  logic             wdata;
  logic [CW-1:0]    gen_count;
  logic             overrun;

  logic             eng_done = 1'b0;
  int               eng_delay = 1;
  logic [255:0]     mem = '0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t sb[$];

  assign gen_done = eng_done;

  gen_scheduler #(
    .POS_W(POS_W),
    .LOG_BASE_PERIOD(2),
    .GEN_CNT_W(CW)
  ) u_dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .speed_in      (speed),
    .step_in       (step),
    .click_in      (click),
    .cursor_x_in   (cx),
    .cursor_y_in   (cy),
    .gen_start_out (gen_start),
    .gen_done_in   (gen_done),
    .gen_busy_out  (gen_busy),
    .edit_x_out    (ex),
    .edit_y_out    (ey),
    .edit_re_out   (edit_re),
    .edit_rdata_in (rdata),
    .edit_we_out   (edit_we),
    .edit_wdata_out(wdata),
    .gen_count_out (gen_count),
    .overrun_out   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int x, input int y, input int d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.x = x; e.y = y; e.d = d;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) next();
  endtask

  // Cell memory behind the edit port: registered read, write on strobe.
  always @(posedge clk) begin
    if (edit_re) rdata <= mem[{ey[3:0], ex[3:0]}];
    if (edit_we) mem[{ey[3:0], ex[3:0]}] <= wdata;
  end

  // Life engine: answers each start with a done pulse eng_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_start) begin
        repeat (eng_delay) @(posedge clk);
        #1 eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int kind;
    ev_t e;
    if (gen_start || edit_re || edit_we) begin
      kind = gen_start ? K_START : (edit_re ? K_RE : K_WE);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", kind, 0);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        if (kind == K_START) begin
          chk("start_busy", int'(gen_busy), 1);
        end else begin
          chk("edit_x", int'(ex), e.x);
          chk("edit_y", int'(ey), e.y);
          if (kind == K_WE) chk("edit_wdata", int'(wdata), e.d);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) next();
    chk("rst_busy", int'(gen_busy), 0);
    chk("rst_start", int'(gen_start), 0);
    chk("rst_re", int'(edit_re), 0);
    chk("rst_we", int'(edit_we), 0);
    chk("rst_ex", int'(ex), 0);
    chk("rst_ey", int'(ey), 0);
    chk("rst_count", int'(gen_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    repeat (2) next();

    // Click at (3,7); a second click one cycle later must be dropped.
    n = cyc;
    click = 1'b1; cx = 10'd3; cy = 10'd7;
    push(K_RE, n + 2, 3, 7, 0);
    push(K_WE, n + 3, 3, 7, 1);
    next();
    cx = 10'd5; cy = 10'd5;
    next();
    click = 1'b0;
    repeat (8) next();
    chk("sb_empty_click", sb.size(), 0);

    // Re-clicking the same cell toggles it back to 0.
    n = cyc;
    click = 1'b1; cx = 10'd3; cy = 10'd7;
    push(K_RE, n + 2, 3, 7, 0);
    push(K_WE, n + 3, 3, 7, 0);
    next();
    click = 1'b0;
    repeat (8) next();
    chk("sb_empty_click2", sb.size(), 0);

    // Single step while paused.
    eng_delay = 1;
    n = cyc;
    step = 1'b1;
    push(K_START, n + 2, 0, 0, 0);
    next();
    step = 1'b0;
    repeat (8) next();
    chk("count_step", int'(gen_count), 1);
    chk("sb_empty_step", sb.size(), 0);

    // Speed 7: period 4, start 6 cycles after the speed change.
    n = cyc;
    speed = 3'd7;
    for (int k = 0; k < 3; k++) push(K_START, n + 6 + 4 * k, 0, 0, 0);
    goto_cyc(n + 15);
    speed = 3'd0;
    repeat (10) next();
    chk("count_speed7", int'(gen_count), 4);
    chk("overrun_speed7", int'(overrun), 0);
    chk("sb_empty_speed7", sb.size(), 0);

    // Speed 5: period 16, paused mid-way through the second period.
    n = cyc;
    speed = 3'd5;
    push(K_START, n + 18, 0, 0, 0);
    goto_cyc(n + 24);
    speed = 3'd0;
    repeat (30) next();
    chk("count_speed5", int'(gen_count), 5);
    chk("sb_empty_speed5", sb.size(), 0);

    // Pending step discarded when speed drops to 0 during a slow generation.
    eng_delay = 20;
    n = cyc;
    speed = 3'd7;
    push(K_START, n + 6, 0, 0, 0);
    goto_cyc(n + 10);
    speed = 3'd0;
    repeat (30) next();
    chk("count_pend_clr", int'(gen_count), 6);
    chk("overrun_pend_clr", int'(overrun), 0);
    chk("sb_empty_pend_clr", sb.size(), 0);

    // Slow engine at speed 7: one queued start right after done, overrun flagged.
    n = cyc;
    speed = 3'd7;
    push(K_START, n + 6, 0, 0, 0);
    push(K_START, n + 28, 0, 0, 0);
    goto_cyc(n + 27);
    speed = 3'd0;
    eng_delay = 1;
    repeat (12) next();
    chk("overrun_set", int'(overrun), 1);
    chk("count_overrun", int'(gen_count), 8);
    chk("sb_empty_overrun", sb.size(), 0);

    // Click and extra step during a generation: edit served first, then one start.
    eng_delay = 10;
    n = cyc;
    step = 1'b1;
    push(K_START, n + 2, 0, 0, 0);
    next();
    step = 1'b0;
    goto_cyc(n + 4);
    step = 1'b1;
    next();
    click = 1'b1; cx = 10'd9; cy = 10'd2;
    push(K_RE, n + 14, 9, 2, 0);
    push(K_WE, n + 15, 9, 2, 1);
    push(K_START, n + 17, 0, 0, 0);
    next();
    step = 1'b0; click = 1'b0;
    goto_cyc(n + 40);
    chk("count_queued", int'(gen_count), 10);
    chk("sb_empty_queued", sb.size(), 0);

    // Reset in GEN_WAIT; the engine's later done must not count.
    n = cyc;
    step = 1'b1;
    push(K_START, n + 2, 0, 0, 0);
    next();
    step = 1'b0;
    goto_cyc(n + 5);
    rst = 1'b1;
    next();
    rst = 1'b0;
    chk("midrst_count", int'(gen_count), 0);
    chk("midrst_busy", int'(gen_busy), 0);
    chk("midrst_overrun", int'(overrun), 0);
    goto_cyc(n + 20);
    chk("midrst_stray_done", int'(gen_count), 0);
    chk("sb_empty_midrst", sb.size(), 0);

    // Counter wrap: all-ones then back to zero.
    eng_delay = 1;
    n = cyc;
    speed = 3'd7;
    for (int k = 0; k < NWRAP; k++) push(K_START, n + 6 + 4 * k, 0, 0, 0);
    goto_cyc(n + 6 + 4 * (NWRAP - 1));
    chk("wrap_allones", int'(gen_count), NWRAP - 1);
    goto_cyc(n + 7 + 4 * (NWRAP - 1));
    speed = 3'd0;
    next();
    chk("wrap_zero", int'(gen_count), 0);
    repeat (6) next();
    chk("sb_empty_wrap", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
